t2c_move_executor: RTL

- Downstream stage of the maze explorer. Accepts one 3-bit move command per handshake and sequences the differential-drive motor enables and directions for a timed turn phase and/or drive phase.
- Maintains the committed pose of the bot: cell x/y and heading. Pulses done on completion so the explorer can sample fresh wall sensors.
- Flags maze exit and illegal or off-grid moves.

---
 rtl/t2c_move_executor_if.sv | 18 +
 rtl/t2c_move_executor.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/t2c_move_executor_if.sv
// rtl/t2c_move_executor_if.sv - move command handshake between explorer and executor
interface t2c_move_executor_if;
  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (
    output cmd,
    output cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd,
    input  cmd_valid,
    output cmd_ready
  );
endinterface

// File: rtl/t2c_move_executor.sv
// rtl/t2c_move_executor.sv - sequences differential-drive motors for one move and tracks pose
module t2c_move_executor #(
  parameter int FWD_CYCLES   = 8,
  parameter int TURN_CYCLES  = 4,
  parameter int UTURN_CYCLES = 8,
  parameter int START_X      = 4,
  parameter int START_Y      = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  t2c_move_executor_if.slave      cmd_if,
  output logic                    mot_l_en,
  output logic                    mot_l_fwd,
  output logic                    mot_r_en,
  output logic                    mot_r_fwd,
  output logic                    done,
  output logic [1:0]              heading,
  output logic [3:0]              x_pos,
  output logic [3:0]              y_pos,
  output logic                    at_exit,
  output logic                    err
);

  localparam logic [7:0] FWD_LEN   = 8'(FWD_CYCLES);
  localparam logic [7:0] TURN_LEN  = 8'(TURN_CYCLES);
  localparam logic [7:0] UTURN_LEN = 8'(UTURN_CYCLES);
  localparam logic [3:0] X_INIT    = 4'(START_X);
  localparam logic [3:0] Y_INIT    = 4'(START_Y);
  localparam logic [3:0] GRID_MAX  = 4'd8;
  localparam logic [3:0] EXIT_X    = 4'd4;

  typedef enum logic [1:0] {S_IDLE, S_TURN, S_DRIVE, S_DONE} state_t;
  typedef enum logic [1:0] {TK_LEFT, TK_RIGHT, TK_UTURN} turn_t;

  state_t     state_q, state_d;
  turn_t      turn_q, turn_d;
  logic [7:0] counter_q, counter_d;
  logic [1:0] heading_q, heading_d;
  logic [3:0] x_q, x_d;
  logic [3:0] y_q, y_d;
  logic       exit_q, exit_d;
  logic       err_q, err_d;

  // Outputs are computed from the next state and registered alongside it.
  logic       ready_q, ready_d;
  logic       done_q, done_d;
  logic [3:0] mot_q, mot_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      turn_q    <= TK_LEFT;
      counter_q <= 8'd0;
      heading_q <= 2'd0;
      x_q       <= X_INIT;
      y_q       <= Y_INIT;
      exit_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      mot_q     <= 4'b0000;
    end else begin
      state_q   <= state_d;
      turn_q    <= turn_d;
      counter_q <= counter_d;
      heading_q <= heading_d;
      x_q       <= x_d;
      y_q       <= y_d;
      exit_q    <= exit_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      mot_q     <= mot_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    turn_d    = turn_q;
    counter_d = counter_q;
    heading_d = heading_q;
    x_d       = x_q;
    y_d       = y_q;
    exit_d    = exit_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_if.cmd_valid) begin
          case (cmd_if.cmd)
            3'd0: state_d = S_DONE;
            3'd1: begin
              state_d   = S_DRIVE;
              counter_d = FWD_LEN;
            end
            3'd2: begin
              state_d   = S_TURN;
              counter_d = TURN_LEN;
              turn_d    = TK_LEFT;
            end
            3'd3: begin
              state_d   = S_TURN;
              counter_d = TURN_LEN;
              turn_d    = TK_RIGHT;
            end
            3'd4: begin
              state_d   = S_TURN;
              counter_d = UTURN_LEN;
              turn_d    = TK_UTURN;
            end
            default: begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      S_TURN: begin
        if (counter_q == 8'd1) begin
          state_d   = S_DRIVE;
          counter_d = FWD_LEN;
          case (turn_q)
            TK_LEFT:  heading_d = heading_q - 2'd1;
            TK_RIGHT: heading_d = heading_q + 2'd1;
            default:  heading_d = heading_q + 2'd2;
          endcase
        end else begin
          counter_d = counter_q - 8'd1;
        end
      end
      S_DRIVE: begin
        if (counter_q == 8'd1) begin
          state_d   = S_DONE;
          counter_d = 8'd0;
          // Off-grid checks happen before any arithmetic so nothing wraps.
          case (heading_q)
            2'd0: begin
              if (y_q == 4'd0) begin
                if (x_q == EXIT_X) exit_d = 1'b1;
                else               err_d  = 1'b1;
              end else begin
                y_d = y_q - 4'd1;
              end
            end
            2'd1: begin
              if (x_q >= GRID_MAX) err_d = 1'b1;
              else                 x_d   = x_q + 4'd1;
            end
            2'd2: begin
              if (y_q >= GRID_MAX) err_d = 1'b1;
              else                 y_d   = y_q + 4'd1;
            end
            default: begin
              if (x_q == 4'd0) err_d = 1'b1;
              else             x_d   = x_q - 4'd1;
            end
          endcase
        end else begin
          counter_d = counter_q - 8'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Motor vector is {l_en, l_fwd, r_en, r_fwd}.
  always_comb begin
    ready_d = (state_d == S_IDLE);
    done_d  = (state_d == S_DONE);
    mot_d   = 4'b0000;
    case (state_d)
      S_TURN:  mot_d = (turn_d == TK_LEFT) ? 4'b1011 : 4'b1110;
      S_DRIVE: mot_d = 4'b1111;
      default: mot_d = 4'b0000;
    endcase
  end

  assign cmd_if.cmd_ready = ready_q;
  assign done             = done_q;
  assign mot_l_en         = mot_q[3];
  assign mot_l_fwd        = mot_q[2];
  assign mot_r_en         = mot_q[1];
  assign mot_r_fwd        = mot_q[0];
  assign heading          = heading_q;
  assign x_pos            = x_q;
  assign y_pos            = y_q;
  assign at_exit          = exit_q;
  assign err              = err_q;

endmodule
